// File: rtl/lv_owt_req_sched_pkg.sv
// Shared widths, FSM encoding, requester ids and request record for the
// LV-side OWT request scheduler.
package lv_owt_req_sched_pkg;

  localparam int CMD_W  = 8;
  localparam int DATA_W = 8;
  localparam int ADCD_W = 10;

  localparam int SCHED_FSM_ST_W = 2;
  localparam logic [SCHED_FSM_ST_W-1:0] SCHED_IDLE_ST = 2'd0;
  localparam logic [SCHED_FSM_ST_W-1:0] SCHED_TX_ST   = 2'd1;
  localparam logic [SCHED_FSM_ST_W-1:0] SCHED_WAIT_ST = 2'd2;
  localparam logic [SCHED_FSM_ST_W-1:0] SCHED_DONE_ST = 2'd3;

  // Read of address 0x1f: the ADC result register on the HV side.
  localparam logic [CMD_W-1:0] DEF_ADC_POLL_CMD = 8'h1f;

  typedef enum logic {
    REQ_SPI = 1'b0,
    REQ_ADC = 1'b1
  } req_id_e;

  typedef struct packed {
    req_id_e           id;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
  } sched_req_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lv_owt_req_sched_if.sv
// SPI-requester and OWT TX/RX handshake bundle seen by the scheduler.
// slv is the scheduler side, mst the SPI block / OWT controllers side.
interface lv_owt_req_sched_if;
  import lv_owt_req_sched_pkg::*;

  logic              i_spi_req;
  logic [CMD_W-1:0]  i_spi_cmd;
  logic [DATA_W-1:0] i_spi_wdata;
  logic              o_spi_ack;
  logic [DATA_W-1:0] o_spi_rdata;
  logic              o_spi_err;

  logic              o_owt_tx_req;
  logic [CMD_W-1:0]  o_owt_tx_cmd;
  logic [DATA_W-1:0] o_owt_tx_data;
  logic              i_owt_tx_ack;

  logic              i_owt_rx_ack;
  logic [CMD_W-1:0]  i_owt_rx_cmd;
  logic [ADCD_W-1:0] i_owt_rx_data;
  logic              i_owt_rx_status;

  modport slv (
    input  i_spi_req, i_spi_cmd, i_spi_wdata,
    output o_spi_ack, o_spi_rdata, o_spi_err,
    output o_owt_tx_req, o_owt_tx_cmd, o_owt_tx_data,
    input  i_owt_tx_ack,
    input  i_owt_rx_ack, i_owt_rx_cmd, i_owt_rx_data, i_owt_rx_status
  );

  modport mst (
    output i_spi_req, i_spi_cmd, i_spi_wdata,
    input  o_spi_ack, o_spi_rdata, o_spi_err,
    input  o_owt_tx_req, o_owt_tx_cmd, o_owt_tx_data,
    output i_owt_tx_ack,
    output i_owt_rx_ack, i_owt_rx_cmd, i_owt_rx_data, i_owt_rx_status
  );

endinterface

// File: rtl/lv_owt_req_sched_poll_tmr.sv
// ADC poll period counter: free-runs while enabled and raises a sticky,
// non-accumulating pend flag on every wrap.
module lv_owt_poll_tmr #(
  parameter int PERIOD = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_pend
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(PERIOD - 1));

  // A grant in the same cycle as a wrap wins: that expiry is absorbed by
  // the poll being granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      o_pend <= 1'b0;
    end else if (!i_en) begin
      cnt    <= '0;
      o_pend <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (i_clr)     o_pend <= 1'b0;
      else if (wrap) o_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/lv_owt_req_sched.sv
// Shares the single OWT transaction slot between SPI register access and
// the periodic ADC poll; handles response matching, timeout and retry.
module lv_owt_req_sched
  import lv_owt_req_sched_pkg::*;
#(
  parameter int               ADC_POLL_CYC    = 1024,
  parameter int               RSP_TIMEOUT_CYC = 2048,
  parameter int               MAX_RETRY       = 2,
  parameter logic [CMD_W-1:0] ADC_POLL_CMD    = DEF_ADC_POLL_CMD
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  lv_owt_req_sched_if.slv   bus,
  input  logic              i_adc_poll_en,
  output logic [ADCD_W-1:0] o_adc_data,
  output logic              o_adc_vld,
  output logic              o_adc_err,
  output logic              o_busy,
  output logic [7:0]        o_fail_cnt
);

  localparam int TW = (RSP_TIMEOUT_CYC > 1) ? $clog2(RSP_TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [SCHED_FSM_ST_W-1:0] state;
  sched_req_t                cur;
  sched_req_t                nxt_req;
  req_id_e                   last_gnt;
  logic [RW-1:0]             retry_cnt;
  logic [TW-1:0]             rsp_tmr;
  logic                      poll_pend;
  logic                      gnt_spi, gnt_adc;
  logic                      rsp_ok, att_end, att_fail, retry_ok;

  lv_owt_poll_tmr #(.PERIOD(ADC_POLL_CYC)) u_poll_tmr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_adc_poll_en),
    .i_clr   (gnt_adc),
    .o_pend  (poll_pend)
  );

  always_comb begin
    gnt_spi  = (state == SCHED_IDLE_ST) && bus.i_spi_req &&
               (!poll_pend || last_gnt == REQ_ADC);
    gnt_adc  = (state == SCHED_IDLE_ST) && poll_pend && !gnt_spi;
    nxt_req  = gnt_spi ? '{REQ_SPI, bus.i_spi_cmd, bus.i_spi_wdata}
                       : '{REQ_ADC, ADC_POLL_CMD, {DATA_W{1'b0}}};
    // rx_ack takes precedence over a coincident timeout.
    rsp_ok   = bus.i_owt_rx_ack && !bus.i_owt_rx_status &&
               (bus.i_owt_rx_cmd == cur.cmd);
    att_end  = (state == SCHED_WAIT_ST) &&
               (bus.i_owt_rx_ack || rsp_tmr == TW'(RSP_TIMEOUT_CYC - 1));
    att_fail = att_end && !rsp_ok;
    retry_ok = 32'(retry_cnt) < MAX_RETRY;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= SCHED_IDLE_ST;
      cur               <= '0;
      last_gnt          <= REQ_ADC;
      retry_cnt         <= '0;
      rsp_tmr           <= '0;
      bus.o_spi_ack     <= 1'b0;
      bus.o_spi_rdata   <= '0;
      bus.o_spi_err     <= 1'b0;
      bus.o_owt_tx_req  <= 1'b0;
      bus.o_owt_tx_cmd  <= '0;
      bus.o_owt_tx_data <= '0;
      o_adc_data        <= '0;
      o_adc_vld         <= 1'b0;
      o_adc_err         <= 1'b0;
      o_busy            <= 1'b0;
      o_fail_cnt        <= '0;
    end else begin
      bus.o_spi_ack <= 1'b0;
      bus.o_spi_err <= 1'b0;
      o_adc_vld     <= 1'b0;
      o_adc_err     <= 1'b0;
      if (att_fail) o_fail_cnt <= sat_inc8(o_fail_cnt);

      case (state)
        SCHED_IDLE_ST: begin
          if (gnt_spi || gnt_adc) begin
            cur               <= nxt_req;
            last_gnt          <= nxt_req.id;
            retry_cnt         <= '0;
            bus.o_owt_tx_req  <= 1'b1;
            bus.o_owt_tx_cmd  <= nxt_req.cmd;
            bus.o_owt_tx_data <= nxt_req.data;
            o_busy            <= 1'b1;
            state             <= SCHED_TX_ST;
          end
        end
        SCHED_TX_ST: begin
          if (bus.i_owt_tx_ack) begin
            bus.o_owt_tx_req <= 1'b0;
            rsp_tmr          <= '0;
            state            <= SCHED_WAIT_ST;
          end
        end
        SCHED_WAIT_ST: begin
          if (att_end) begin
            if (att_fail && retry_ok) begin
              // tx_cmd/tx_data still hold the granted request.
              retry_cnt        <= retry_cnt + RW'(1);
              bus.o_owt_tx_req <= 1'b1;
              state            <= SCHED_TX_ST;
            end else begin
              state <= SCHED_DONE_ST;
              if (cur.id == REQ_SPI) begin
                bus.o_spi_ack   <= 1'b1;
                bus.o_spi_err   <= att_fail;
                bus.o_spi_rdata <= att_fail ? '0 : bus.i_owt_rx_data[DATA_W-1:0];
              end else if (att_fail) begin
                o_adc_err <= 1'b1;
              end else begin
                o_adc_vld  <= 1'b1;
                o_adc_data <= bus.i_owt_rx_data;
              end
            end
          end else begin
            rsp_tmr <= rsp_tmr + TW'(1);
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= SCHED_IDLE_ST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lv_owt_req_sched.sv
// Randomized bench for lv_owt_req_sched: the bench plays SPI requester and
// OWT peer and predicts every transaction outcome from its per-attempt plan.
module tb_lv_owt_req_sched;
  import lv_owt_req_sched_pkg::*;

  localparam int T  = 64;
  localparam int P  = 16;
  localparam int MR = 2;
  localparam int K_OK = 0, K_STAT = 1, K_BAD = 2, K_NONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        poll_en;
  logic [9:0]  adc_data;
  logic        adc_vld, adc_err, busy;
  logic [7:0]  fail_cnt;

  always #5 clk = ~clk;

  lv_owt_req_sched_if bus();

  lv_owt_req_sched #(
    .ADC_POLL_CYC    (P),
    .RSP_TIMEOUT_CYC (T),
    .MAX_RETRY       (MR)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .bus           (bus),
    .i_adc_poll_en (poll_en),
    .o_adc_data    (adc_data),
    .o_adc_vld     (adc_vld),
    .o_adc_err     (adc_err),
    .o_busy        (busy),
    .o_fail_cnt    (fail_cnt)
  );

  int         n_chk = 0;
  int         n_err = 0;
  int         fail_exp;
  logic [9:0] adc_exp;
  int         att_kind [MR+1];
  int         att_k    [MR+1];
  logic [9:0] att_dat  [MR+1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_att();
    for (int a = 0; a <= MR; a++) begin
      att_kind[a] = $urandom_range(0, 3);
      att_k[a]    = ($urandom_range(0, 3) == 0) ? T - 1 : $urandom_range(0, T - 2);
      att_dat[a]  = 10'($urandom);
    end
  endtask

  task automatic long_ok_att();
    for (int a = 0; a <= MR; a++) begin
      att_kind[a] = K_OK;
      att_k[a]    = $urandom_range(20, 40);
      att_dat[a]  = 10'($urandom);
    end
  endtask

  // One OWT attempt. Returns on the negedge where its outcome is visible.
  task automatic serve_attempt(input logic [7:0] ecmd, input logic [7:0] edata,
                               input int kind, input int k, input logic [9:0] rdat);
    int w;
    int d;
    bit stray;
    w = 0;
    while (bus.o_owt_tx_req !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("tx_req", 32'(bus.o_owt_tx_req), 32'd1);
    chk("tx_cmd", 32'(bus.o_owt_tx_cmd), 32'(ecmd));
    chk("tx_data", 32'(bus.o_owt_tx_data), 32'(edata));
    d     = $urandom_range(0, 3);
    stray = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < d; i++) begin
      bus.i_owt_rx_ack    = stray;
      bus.i_owt_rx_status = 1'b0;
      bus.i_owt_rx_cmd    = ecmd;
      @(negedge clk);
      bus.i_owt_rx_ack = 1'b0;
    end
    chk("tx_hold", 32'(bus.o_owt_tx_req), 32'd1);
    bus.i_owt_tx_ack = 1'b1;
    @(negedge clk);
    bus.i_owt_tx_ack = 1'b0;
    chk("tx_drop", 32'(bus.o_owt_tx_req), 32'd0);
    if (kind == K_NONE) begin
      repeat (T - 1) @(negedge clk);
      chk("no_early", 32'({bus.o_owt_tx_req, bus.o_spi_ack, adc_vld, adc_err}), 32'd0);
      @(negedge clk);
    end else begin
      for (int j = 0; j < k; j++) begin
        bus.i_owt_tx_ack = stray && (j == 0);
        @(negedge clk);
        bus.i_owt_tx_ack = 1'b0;
      end
      bus.i_owt_rx_ack    = 1'b1;
      bus.i_owt_rx_status = (kind == K_STAT);
      bus.i_owt_rx_cmd    = (kind == K_BAD) ? (ecmd ^ 8'h40) : ecmd;
      bus.i_owt_rx_data   = rdat;
      @(negedge clk);
      bus.i_owt_rx_ack    = 1'b0;
      bus.i_owt_rx_status = 1'b0;
      bus.i_owt_rx_data   = 10'($urandom);
    end
  endtask

  // Whole transaction from the current att_* plan: first success among
  // MR+1 attempts wins, otherwise the requester sees an error.
  task automatic run_txn(input bit is_spi, input logic [7:0] cmd, input logic [7:0] wdata,
                         input bit dis_poll, input bit nxt,
                         input logic [7:0] ncmd, input logic [7:0] nwdata);
    logic [7:0] ecmd, edata;
    logic [9:0] rd;
    bit         ok;
    ecmd  = is_spi ? cmd : 8'h1f;
    edata = is_spi ? wdata : 8'h00;
    ok    = 1'b0;
    rd    = '0;
    for (int a = 0; a <= MR; a++) begin
      serve_attempt(ecmd, edata, att_kind[a], att_k[a], att_dat[a]);
      if (att_kind[a] == K_OK) begin
        ok = 1'b1;
        rd = att_dat[a];
        break;
      end
      if (fail_exp < 255) fail_exp++;
      if (a < MR) chk("retry", 32'(bus.o_owt_tx_req), 32'd1);
    end
    if (is_spi) begin
      chk("spi_ack", 32'(bus.o_spi_ack), 32'd1);
      chk("spi_err", 32'(bus.o_spi_err), 32'(!ok));
      chk("spi_rdata", 32'(bus.o_spi_rdata), ok ? 32'(rd[7:0]) : 32'd0);
      bus.i_spi_req = 1'b0;
    end else begin
      chk("adc_vld", 32'(adc_vld), 32'(ok));
      chk("adc_err", 32'(adc_err), 32'(!ok));
      if (ok) adc_exp = rd;
      chk("adc_data", 32'(adc_data), 32'(adc_exp));
    end
    chk("fail_cnt", 32'(fail_cnt), 32'(fail_exp));
    if (dis_poll) poll_en = 1'b0;
    if (nxt) begin
      bus.i_spi_req   = 1'b1;
      bus.i_spi_cmd   = ncmd;
      bus.i_spi_wdata = nwdata;
    end
    @(negedge clk);
    chk("one_cycle", 32'({bus.o_spi_ack, adc_vld, adc_err, busy}), 32'd0);
  endtask

  task automatic quiet_window(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.i_owt_rx_ack = (i == 3);
      bus.i_owt_tx_ack = (i == 5);
      @(negedge clk);
      bus.i_owt_rx_ack = 1'b0;
      bus.i_owt_tx_ack = 1'b0;
      seen |= bus.o_owt_tx_req | bus.o_spi_ack | busy;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    fail_exp = 0;
    adc_exp  = '0;
    @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, wd, c2, wd2;
    int         w;
    bus.i_spi_req       = 1'b0;
    bus.i_spi_cmd       = '0;
    bus.i_spi_wdata     = '0;
    bus.i_owt_tx_ack    = 1'b0;
    bus.i_owt_rx_ack    = 1'b0;
    bus.i_owt_rx_cmd    = '0;
    bus.i_owt_rx_data   = '0;
    bus.i_owt_rx_status = 1'b0;
    poll_en  = 1'b0;
    fail_exp = 0;
    adc_exp  = '0;

    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({bus.o_owt_tx_req, bus.o_spi_ack, bus.o_spi_err, adc_vld, adc_err, busy}), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_adc_data", 32'(adc_data), 32'd0);
    chk("rst_bus", 32'({bus.o_spi_rdata, bus.o_owt_tx_cmd, bus.o_owt_tx_data}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // SPI write, response after 50 cycles.
    bus.i_spi_req   = 1'b1;
    bus.i_spi_cmd   = 8'h85;
    bus.i_spi_wdata = 8'h3c;
    @(negedge clk);
    chk("lat1_tx_req", 32'(bus.o_owt_tx_req), 32'd1);
    chk("lat1_busy", 32'(busy), 32'd1);
    att_kind[0] = K_OK; att_k[0] = 50; att_dat[0] = 10'h03c;
    run_txn(1'b1, 8'h85, 8'h3c, 1'b0, 1'b0, 8'h00, 8'h00);

    // Three silent attempts.
    for (int a = 0; a <= MR; a++) begin att_kind[a] = K_NONE; att_k[a] = 0; att_dat[a] = '0; end
    bus.i_spi_req = 1'b1; bus.i_spi_cmd = 8'h12; bus.i_spi_wdata = 8'h00;
    run_txn(1'b1, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

    // Status error, command mismatch, then success exactly at timeout.
    att_kind[0] = K_STAT; att_k[0] = 5;     att_dat[0] = 10'h0aa;
    att_kind[1] = K_BAD;  att_k[1] = 10;    att_dat[1] = 10'h0bb;
    att_kind[2] = K_OK;   att_k[2] = T - 1; att_dat[2] = 10'h155;
    bus.i_spi_req = 1'b1; bus.i_spi_cmd = 8'h07; bus.i_spi_wdata = 8'h00;
    run_txn(1'b1, 8'h07, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rand_att();
      c  = 8'($urandom);
      wd = 8'($urandom);
      bus.i_spi_req = 1'b1; bus.i_spi_cmd = c; bus.i_spi_wdata = wd;
      run_txn(1'b1, c, wd, 1'b0, 1'b0, 8'h00, 8'h00);
    end

    // ADC polling: first request lands exactly P+1 cycles after enable.
    poll_en = 1'b1;
    repeat (P) @(negedge clk);
    chk("poll_pre", 32'(bus.o_owt_tx_req), 32'd0);
    @(negedge clk);
    chk("poll_period", 32'(bus.o_owt_tx_req), 32'd1);
    att_kind[0] = K_OK; att_k[0] = $urandom_range(0, 30); att_dat[0] = 10'h2a5;
    run_txn(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int n = 0; n < 4; n++) begin
      rand_att();
      run_txn(1'b0, 8'h00, 8'h00, n == 3, 1'b0, 8'h00, 8'h00);
    end
    quiet_window("poll_off_quiet", 40);

    // Reset while waiting for a response.
    bus.i_spi_req = 1'b1; bus.i_spi_cmd = 8'h44; bus.i_spi_wdata = 8'h11;
    w = 0;
    while (bus.o_owt_tx_req !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("rst_mid_tx_req", 32'(bus.o_owt_tx_req), 32'd1);
    bus.i_owt_tx_ack = 1'b1;
    @(negedge clk);
    bus.i_owt_tx_ack = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    bus.i_spi_req = 1'b0;
    #1;
    chk("rst_mid_ctl", 32'({bus.o_owt_tx_req, bus.o_spi_ack, bus.o_spi_err, adc_vld, adc_err, busy}), 32'd0);
    chk("rst_mid_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_mid_adc_data", 32'(adc_data), 32'd0);
    fail_exp = 0;
    adc_exp  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window("no_ghost_ack", T + 10);
    rand_att();
    bus.i_spi_req = 1'b1; bus.i_spi_cmd = 8'h44; bus.i_spi_wdata = 8'h11;
    run_txn(1'b1, 8'h44, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);

    // Arbitration ties from reset: SPI, ADC, SPI, ADC.
    do_reset();
    c   = 8'($urandom); wd  = 8'($urandom);
    c2  = 8'($urandom); wd2 = 8'($urandom);
    poll_en = 1'b1;
    repeat (P) @(negedge clk);
    bus.i_spi_req = 1'b1; bus.i_spi_cmd = c; bus.i_spi_wdata = wd;
    @(negedge clk);
    chk("tie1_tx_req", 32'(bus.o_owt_tx_req), 32'd1);
    chk("tie1_spi_cmd", 32'(bus.o_owt_tx_cmd), 32'(c));
    long_ok_att();
    run_txn(1'b1, c, wd, 1'b0, 1'b1, c2, wd2);
    long_ok_att();
    run_txn(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    long_ok_att();
    run_txn(1'b1, c2, wd2, 1'b0, 1'b0, 8'h00, 8'h00);
    long_ok_att();
    run_txn(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
    quiet_window("tie_end_quiet", 40);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
